// File: rtl/uart_rx_pio_edge.sv
// Avalon-MM input port: synchronised pins, sticky per-bit edge capture (W1C),
// interrupt mask with level irq, and a saturating edge-event counter.
module uart_rx_pio_edge #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_COUNT    = 2'd1,
    REG_MASK     = 2'd2,
    REG_EDGE_CAP = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0]     sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_q;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     ev;
  logic [WIDTH-1:0]     clr;
  logic [WIDTH-1:0]     cap;
  logic [WIDTH-1:0]     mask;
  logic [CNT_WIDTH-1:0] count;
  logic [31:0]          rd_mux;
  logic                 wr;

  assign wr = chipselect & ~write_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchroniser array is a flop chain, so each stage is reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev_q <= sync_q;
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Edge selection is fixed at elaboration; only one branch survives synthesis.
  always_comb begin
    if (EDGE_TYPE == 0)      ev = sync_q & ~prev_q;
    else if (EDGE_TYPE == 1) ev = ~sync_q & prev_q;
    else                     ev = sync_q ^ prev_q;
  end

  assign clr = (wr && (address == REG_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

  // A clear and a new edge on the same bit in one cycle keep the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap  <= '0;
      mask <= '0;
    end else begin
      cap <= (cap & ~clr) | ev;
      if (wr && (address == REG_MASK)) mask <= writedata[WIDTH-1:0];
    end
  end

  // Clear wins over a coincident event; the counter holds at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (wr && (address == REG_COUNT)) begin
      count <= '0;
    end else if ((|ev) && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    unique case (reg_addr_e'(address))
      REG_DATA:     rd_mux[WIDTH-1:0]     = sync_q;
      REG_COUNT:    rd_mux[CNT_WIDTH-1:0] = count;
      REG_MASK:     rd_mux[WIDTH-1:0]     = mask;
      REG_EDGE_CAP: rd_mux[WIDTH-1:0]     = cap;
    endcase
  end

  // Read data is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(cap & mask);

endmodule
